hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides whether PC, IF/ID and ID/EX advance, hold, flush or take a bubble. It resolves three conditions:
- load-use hazards (1-cycle bubble);
- multi-cycle multiply/divide issue (fixed-latency hold);
- data-memory wait (whole-pipeline freeze);
- plus taken-branch flush.

It sits beside the ID stage; its outputs drive the pipeline-register write enables and the bubble mux that zeroes the WB/M/EX control fields entering ID/EX.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 14 +
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encodings and constants for the hazard controller
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_BAD      = 2'd3
  } state_t;

  // Instruction word loaded into IF/ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use compare between the EX-stage load and ID sources
module hazard_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  // $zero never carries a real dependency
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - PC/IF/ID/ID-EX sequencing: load-use bubble, MDU hold, memory freeze, branch flush
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_mdu_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic       branch_taken_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  output logic       pc_we_o,
  output logic       ifid_we_o,
  output logic       ifid_flush_o,
  output logic       idex_bubble_o,
  output logic       pipe_freeze_o,
  output logic       mdu_busy_o,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 2);

  state_t           state_q;
  state_t           ret_q;
  state_t           eff;
  logic [CNT_W-1:0] cnt_q;
  logic             freeze;
  logic             lu;
  logic             mdu_entry;

  hazard_detect u_detect (
    .ex_memread (idex_memread_i),
    .ex_rt      (idex_rt_i),
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .load_use   (lu)
  );

  assign freeze = dmem_req_i & ~dmem_ack_i;

  // Behaviour-defining state: MEM_WAIT acts as the state it will resume
  always_comb begin
    eff = ST_RUN;
    case (state_q)
      ST_MDU_WAIT: eff = ST_MDU_WAIT;
      ST_MEM_WAIT: eff = (ret_q == ST_MDU_WAIT) ? ST_MDU_WAIT : ST_RUN;
      default:     eff = ST_RUN;
    endcase
  end

  assign mdu_entry = (eff == ST_RUN) && !lu && id_mdu_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else if (freeze) begin
      if (state_q != ST_MEM_WAIT) begin
        ret_q   <= eff;
        state_q <= ST_MEM_WAIT;
      end
    end else begin
      case (eff)
        ST_MDU_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_MDU_WAIT;
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (mdu_entry) begin
            state_q <= ST_MDU_WAIT;
            cnt_q   <= CNT_INIT;
          end else begin
            state_q <= ST_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    pc_we_o       = 1'b1;
    ifid_we_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    mdu_busy_o    = 1'b0;
    if (freeze) begin
      pipe_freeze_o = 1'b1;
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
    end else if (eff == ST_MDU_WAIT || mdu_entry) begin
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      idex_bubble_o = 1'b1;
      mdu_busy_o    = 1'b1;
    end else if (lu) begin
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      ifid_flush_o  = branch_taken_i;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_mdu, idex_memread, branch_taken, dmem_req, dmem_ack;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, mdu_busy;
  logic [1:0] state;

  int passes = 0;
  int checks = 0;
  int holds  = 0;

  // Reference model: remaining MDU hold cycles and whether last cycle was frozen
  int mdu_rem    = 0;
  bit was_frozen = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(3)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_mdu_i       (id_mdu),
    .idex_memread_i (idex_memread),
    .idex_rt_i      (idex_rt),
    .branch_taken_i (branch_taken),
    .dmem_req_i     (dmem_req),
    .dmem_ack_i     (dmem_ack),
    .pc_we_o        (pc_we),
    .ifid_we_o      (ifid_we),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .pipe_freeze_o  (pipe_freeze),
    .mdu_busy_o     (mdu_busy),
    .state_o        (state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mdu, input logic br,
                       input logic req, input logic ack);
    idex_memread = mr;  idex_rt = xrt;  id_rs = rs;  id_rt = rt;
    id_mdu = mdu;  branch_taken = br;  dmem_req = req;  dmem_ack = ack;
  endtask

  // Called just after a rising edge with inputs driven; checks mid-cycle, advances the model
  task automatic step(input int st_exp = -1);
    logic frz, lu, e_pc, e_ifid, e_fl, e_bub, e_busy;
    logic [1:0] e_st;
    #4;
    frz = dmem_req && !dmem_ack;
    lu  = idex_memread && idex_rt != 0 && (idex_rt == id_rs || idex_rt == id_rt);
    e_pc = 1'b0; e_ifid = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_busy = 1'b0;
    if (frz) begin
    end else if (mdu_rem > 0 || (!lu && id_mdu)) begin
      e_bub = 1'b1; e_busy = 1'b1;
    end else if (lu) begin
      e_bub = 1'b1;
    end else begin
      e_pc = 1'b1; e_ifid = 1'b1; e_fl = branch_taken;
    end
    e_st = was_frozen ? 2'd2 : (mdu_rem > 0 ? 2'd1 : 2'd0);
    chk("pc_we", pc_we, e_pc);
    chk("ifid_we", ifid_we, e_ifid);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("idex_bubble", idex_bubble, e_bub);
    chk("pipe_freeze", pipe_freeze, frz);
    chk("mdu_busy", mdu_busy, e_busy);
    chk("state", state, e_st);
    if (st_exp >= 0) chk("state_seq", state, st_exp[7:0]);
    if (pc_we === 1'b0) holds++;
    if (!frz) begin
      if (mdu_rem > 0) mdu_rem--;
      else if (!lu && id_mdu) mdu_rem = MDU_LAT - 1;
    end
    was_frozen = frz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_pc_we", pc_we, 1);
    chk("rst_ifid_we", ifid_we, 1);
    chk("rst_flush", ifid_flush, 0);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_freeze", pipe_freeze, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: one bubble, then no stall for $zero destination
    drive(1, 8, 8, 3, 0, 0, 0, 0); step(0);
    chk("lu_bubble", idex_bubble, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step(0);

    // MDU hold: 4 cycles, state 0,1,1,1 then back to 0
    holds = 0;
    drive(0, 0, 1, 2, 1, 0, 0, 0); step(0);
    drive(0, 0, 1, 2, 0, 0, 0, 0); step(1); step(1); step(1);
    step(0);
    chk("mdu_hold_cycles", holds[7:0], 4);

    // Memory wait: 3 frozen cycles then ack
    drive(0, 0, 0, 0, 0, 0, 1, 0); step(0); step(2); step(2);
    drive(0, 0, 0, 0, 0, 0, 1, 1); step(2);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(0);

    // Freeze injected at the 2nd MDU cycle: 6 held cycles
    holds = 0;
    drive(0, 0, 0, 0, 1, 0, 0, 0); step(0);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step(1); step(2);
    drive(0, 0, 0, 0, 0, 0, 1, 1); step(2);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(1); step(1);
    step(0);
    chk("mdu_freeze_hold", holds[7:0], 6);

    // Branch priority below load-use
    drive(1, 5, 5, 0, 0, 1, 0, 0); step(0);
    drive(0, 0, 5, 0, 0, 1, 0, 0); step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(0);

    // Async reset while in MEM_WAIT
    drive(0, 0, 0, 0, 0, 0, 1, 0); step(0); step(2);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_pc_we", pc_we, 1);
    chk("arst_freeze", pipe_freeze, 0);
    chk("arst_bubble", idex_bubble, 0);
    mdu_rem = 0;
    was_frozen = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
